// File: rtl/vector_stim_gen.sv
// rtl/vector_stim_gen.sv - restartable step sequencer driving the vector block inputs
// Optional feature macro: VECTOR_STIM_LOOP_EN (continuous looping instead of single run).
module vector_stim_gen #(
  parameter int NUM_STEPS = 20,
  parameter int SHIFT_MAX = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        out_ready,
  output logic        out_valid,
  output logic        busy,
  output logic        done,
  output logic [7:0]  step_idx,
  output logic [3:0]  vector_0_in,
  output logic        scala_1_in,
  output logic [12:0] vector_2_in,
  output logic [3:0]  vector_3_in_0,
  output logic [3:0]  vector_3_in_1,
  output logic [3:0]  vector_3_in_2
);

`ifdef VECTOR_STIM_LOOP_EN
  localparam bit LP_LOOP = 1'b1;
`else
  localparam bit LP_LOOP = 1'b0;
`endif

  localparam logic [7:0] LP_LAST      = 8'(NUM_STEPS - 1);
  localparam logic [3:0] LP_SHIFT_MAX = 4'(SHIFT_MAX);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      r_state;
  logic        r_out_valid;
  logic        r_busy;
  logic        r_done;
  logic [7:0]  r_step_idx;
  logic [3:0]  r_vector_0;
  logic        r_scala_1;
  logic [3:0]  r_shift;
  logic [12:0] r_vector_2;
  logic [3:0]  r_vector_3_0;
  logic [3:0]  r_vector_3_1;
  logic [3:0]  r_vector_3_2;

  logic        w_hs;
  logic        w_last;
  logic        w_load0;
  logic        w_step;
  logic [3:0]  w_shift_n;

  assign w_hs    = r_out_valid & out_ready;
  assign w_last  = (r_step_idx == LP_LAST);
  // Step 0 is loaded either by a fresh start or by the wrap of a looping pass.
  assign w_load0 = ((r_state == S_IDLE) && start) || (w_hs && w_last && LP_LOOP);
  assign w_step  = w_hs & ~w_last;
  assign w_shift_n = w_load0 ? 4'd0 :
                     ((r_shift == LP_SHIFT_MAX) ? 4'd0 : r_shift + 4'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_step_idx   <= 8'd0;
      r_vector_0   <= 4'd0;
      r_scala_1    <= 1'b0;
      r_shift      <= 4'd0;
      r_vector_2   <= 13'd0;
      r_vector_3_0 <= 4'd0;
      r_vector_3_1 <= 4'd0;
      r_vector_3_2 <= 4'd0;
    end else if (abort) begin
      r_state      <= S_IDLE;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_step_idx   <= 8'd0;
      r_vector_0   <= 4'd0;
      r_scala_1    <= 1'b0;
      r_shift      <= 4'd0;
      r_vector_2   <= 13'd0;
      r_vector_3_0 <= 4'd0;
      r_vector_3_1 <= 4'd0;
      r_vector_3_2 <= 4'd0;
    end else begin
      if (w_load0 || w_step) begin
        r_step_idx   <= w_load0 ? 8'd0 : r_step_idx + 8'd1;
        r_vector_0   <= w_load0 ? 4'd1 : r_vector_0 + 4'd1;
        r_scala_1    <= w_load0 ? 1'b1 : ~r_scala_1;
        r_shift      <= w_shift_n;
        r_vector_2   <= 13'd1 << w_shift_n;
        r_vector_3_0 <= w_shift_n;
        r_vector_3_1 <= w_shift_n + 4'd1;
        r_vector_3_2 <= w_shift_n + 4'd2;
      end
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state     <= S_RUN;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        S_RUN: begin
          r_done <= w_hs & w_last;
          if (w_hs && w_last && !LP_LOOP) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid     = r_out_valid;
  assign busy          = r_busy;
  assign done          = r_done;
  assign step_idx      = r_step_idx;
  assign vector_0_in   = r_vector_0;
  assign scala_1_in    = r_scala_1;
  assign vector_2_in   = r_vector_2;
  assign vector_3_in_0 = r_vector_3_0;
  assign vector_3_in_1 = r_vector_3_1;
  assign vector_3_in_2 = r_vector_3_2;

endmodule

// File: tb/tb_vector_stim_gen.sv
// tb/tb_vector_stim_gen.sv - scoreboard bench for vector_stim_gen
module tb_vector_stim_gen;

  localparam int N_STEPS = 20;
  localparam int S_MAX   = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid, busy, done, scala_1_in;
  logic [7:0]  step_idx;
  logic [3:0]  vector_0_in, vector_3_in_0, vector_3_in_1, vector_3_in_2;
  logic [12:0] vector_2_in;

  logic        start1 = 1'b0;
  logic        abort1 = 1'b0;
  logic        ready1 = 1'b0;
  logic        valid1, busy1, done1, s1_1;
  logic [7:0]  idx1;
  logic [3:0]  v0_1, v3a_1, v3b_1, v3c_1;
  logic [12:0] v2_1;

  vector_stim_gen u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .out_ready(out_ready),
    .out_valid(out_valid), .busy(busy), .done(done), .step_idx(step_idx),
    .vector_0_in(vector_0_in), .scala_1_in(scala_1_in), .vector_2_in(vector_2_in),
    .vector_3_in_0(vector_3_in_0), .vector_3_in_1(vector_3_in_1), .vector_3_in_2(vector_3_in_2)
  );

  vector_stim_gen #(.NUM_STEPS(1), .SHIFT_MAX(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .out_ready(ready1),
    .out_valid(valid1), .busy(busy1), .done(done1), .step_idx(idx1),
    .vector_0_in(v0_1), .scala_1_in(s1_1), .vector_2_in(v2_1),
    .vector_3_in_0(v3a_1), .vector_3_in_1(v3b_1), .vector_3_in_2(v3c_1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  idx;
    logic [3:0]  v0;
    logic        s1;
    logic [12:0] v2;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [3:0]  c;
  } step_t;

  step_t exp_q[$];
  step_t mon_act;
  step_t mon_exp;
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    exp_done_cyc = -1;
  int    done_seen_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: step k is derived directly from its index.
  function automatic step_t model_step(input int k, input int smax);
    step_t s;
    int    sh;
    sh    = k % (smax + 1);
    s.idx = 8'(k);
    s.v0  = 4'((k + 1) % 16);
    s.s1  = ((k % 2) == 0);
    s.v2  = 13'(1 << sh);
    s.a   = 4'(sh);
    s.b   = 4'(sh + 1);
    s.c   = 4'(sh + 2);
    return s;
  endfunction

  function automatic logic [63:0] all_outs();
    return 64'({out_valid, busy, done, step_idx, vector_0_in, scala_1_in,
                vector_2_in, vector_3_in_0, vector_3_in_1, vector_3_in_2});
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_seen_cyc = cyc;
      if (done || cyc == exp_done_cyc) check("done_timing", 64'(done), 64'(cyc == exp_done_cyc));
      if (out_valid && out_ready && !abort) begin
        mon_act = {step_idx, vector_0_in, scala_1_in, vector_2_in,
                   vector_3_in_0, vector_3_in_1, vector_3_in_2};
        if (exp_q.size() == 0) begin
          check("unexpected_step", 64'(mon_act), 64'(0));
        end else begin
          mon_exp = exp_q.pop_front();
          check("step", 64'(mon_act), 64'(mon_exp));
          if (mon_exp.idx == 8'(N_STEPS - 1)) exp_done_cyc = cyc + 1;
        end
      end
    end
  end

  task automatic load_expected();
    exp_q.delete();
    exp_done_cyc  = -1;
    done_seen_cyc = -1;
    for (int k = 0; k < N_STEPS; k++) exp_q.push_back(model_step(k, S_MAX));
  endtask

  function automatic logic ready_for(input int mode, input int rel);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ((rel % 2) == 0);
    return 1'($urandom_range(0, 1));
  endfunction

  // mode 0: ready high, 1: ready toggling, 2: random ready
  task automatic do_run(input int mode, input bit poke_start, input int exp_rel_done);
    int  t0;
    bit  finished;
    load_expected();
    @(posedge clk); #1;
    start = 1'b1;
    t0 = cyc;
    out_ready = ready_for(mode, 0);
    finished = 1'b0;
    for (int c = 1; c < 400; c++) begin
      @(posedge clk); #1;
      start = (poke_start && c == 5);
      out_ready = ready_for(mode, c);
      if (done_seen_cyc > t0) begin
        finished = 1'b1;
        break;
      end
    end
    start = 1'b0;
    check("run_completes", 64'(finished), 64'(1));
    if (exp_rel_done > 0) check("done_cycle", 64'(done_seen_cyc - t0), 64'(exp_rel_done));
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    @(negedge clk);
    check("idle_after_done", 64'({out_valid, busy, done}), 64'(0));
    check("data_held", 64'({vector_0_in, step_idx}), 64'({4'd4, 8'd19}));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", all_outs(), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", all_outs(), 64'(0));

    do_run(0, 1'b1, N_STEPS + 1);
    do_run(1, 1'b0, 2 * N_STEPS + 1);
    do_run(2, 1'b0, 0);

    begin : abort_test
      bit found;
      load_expected();
      @(posedge clk); #1;
      start = 1'b1;
      out_ready = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 50; c++) begin
        @(posedge clk); #1;
        start = 1'b0;
        if (out_valid && step_idx == 8'd7) begin
          found = 1'b1;
          break;
        end
      end
      check("reach_step7", 64'(found), 64'(1));
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_outputs", all_outs(), 64'(0));
      exp_q.delete();
      repeat (4) @(posedge clk);
      #1;
      check("abort_no_done", 64'(done_seen_cyc), 64'(-1));
      check("abort_idle", 64'(out_valid), 64'(0));
    end

    begin : reset_test
      load_expected();
      @(posedge clk); #1;
      start = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("reset_midrun", all_outs(), 64'(0));
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_release_idle", 64'({out_valid, done}), 64'(0));
      check("reset_no_done", 64'(done_seen_cyc), 64'(-1));
    end

    begin : single_step_test
      @(posedge clk); #1;
      start1 = 1'b1;
      ready1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      check("n1_step0", 64'({valid1, busy1, done1, idx1, v0_1, s1_1, v2_1, v3a_1, v3b_1, v3c_1}),
            64'({1'b1, 1'b1, 1'b0, 8'd0, 4'd1, 1'b1, 13'h0001, 4'd0, 4'd1, 4'd2}));
      @(posedge clk); #1;
      check("n1_done", 64'({valid1, busy1, done1}), 64'({1'b0, 1'b0, 1'b1}));
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      check("n1_idle", 64'({valid1, done1}), 64'(0));
      @(posedge clk); #1;
      check("n1_start_in_done_ignored", 64'(valid1), 64'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vector_stim_gen.md
# vector_stim_gen

Sequential stimulus sequencer that sits directly upstream of the combinational `vector` block. It generates that block's complete input bundle (`vector_0_in`, `scala_1_in`, `vector_2_in`, `vector_3_in_0..2`) as a fixed, deterministic step sequence. Each step is held under a valid/ready handshake so the downstream consumer or checker can stall it. The block replaces free-running bench stimulus with a synthesizable, restartable source.

## Interface
- `NUM_STEPS`, default 20: steps per run, legal range 1..255.
- `SHIFT_MAX`, default 12: last one-hot shift position before the shift wraps to 0, legal range 0..12.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `start`  in  1  begin a run; sampled only in IDLE.
- `abort`  in  1  synchronous cancel of a run, from any state.
- `out_ready`  in  1  downstream accepts the current step.
- `out_valid`  out  1  step values are valid.
- `busy`  out  1  run in progress (state RUN).
- `done`  out  1  one-cycle pulse after the last step is accepted.
- `step_idx`  out  8  index of the step currently presented.
- `vector_0_in`  out  4  step counter value.
- `scala_1_in`  out  1  toggle.
- `vector_2_in`  out  13  one-hot, bit `shift` set.
- `vector_3_in_0` / `_1` / `_2`  out  4 each  `shift`, `shift+1`, `shift+2`.

## Operation
- States are IDLE, RUN and DONE. Reset forces IDLE, and every output is 0. Internal `shift` resets to 0.
- **IDLE**
  - `start=1` moves to RUN.
  - Step 0 loads: `vector_0_in=1`, `scala_1_in=1`, `shift=0`, `vector_2_in=13'h0001`, `vector_3_in_0/1/2=0/1/2`, `step_idx=0`.
- **RUN**
  - `out_valid=1` and `busy=1`.
  - On a handshake (`out_valid & out_ready`), the next step loads:
    - `vector_0_in` increments modulo 16 (15 -> 0).
    - `scala_1_in` inverts.
    - `shift` increments, wrapping `SHIFT_MAX` -> 0.
    - `vector_2_in = 1 << shift`.
    - `vector_3_in_0/1/2 = shift, shift+1, shift+2`. The maximum is 14, so these never overflow 4 bits.
    - `step_idx` increments.
  - Without a handshake, every output holds its value.
- **Last step**: a handshake with `step_idx == NUM_STEPS-1` moves to DONE. The data outputs hold the last step's values.
- **DONE**: `done=1`, `out_valid=0`, `busy=0` for exactly one cycle, then IDLE. The data outputs keep the last step's values until the next `start`, `abort` or reset.
- **`start` outside IDLE**: ignored, including in the DONE cycle.
- **`abort=1` in any state**
  - Next state is IDLE and every output returns to its reset value.
  - `done` does not pulse.
  - `abort` has priority over `start` and over a handshake in the same cycle.
- **Reset mid-run**: immediate return to IDLE with all outputs 0. There is no partial `done`.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- `start` high in cycle T (IDLE): `out_valid` and step 0 appear at T+1.
- With `out_ready` held high, step k is presented in cycle T+1+k. The last step is at T+`NUM_STEPS`, and `done` pulses at T+`NUM_STEPS`+1.
- The earliest next accepted `start` is T+`NUM_STEPS`+2.
- Dropping `out_ready` stalls the sequence one cycle per low cycle. `out_valid` never drops mid-run except on `abort`.
- Throughput is one step per cycle.

## Configuration
- `VECTOR_STIM_LOOP_EN` defined:
  - The handshake on the last step reloads step 0 values in the next cycle, and the block stays in RUN with `out_valid=1`.
  - `done` pulses for one cycle coincident with step 0 of the new pass.
  - The block exits only on `abort` or reset.
  - `scala_1_in` and `shift` restart from the step-0 values; they do not continue.
- `VECTOR_STIM_LOOP_EN` undefined: single run with the DONE/IDLE behaviour above.

## Test plan
- **Reset**: hold `rst_n=0` mid-run -> all outputs 0 immediately; after release the block is in IDLE with `out_valid=0`.
- **Default run**: `start` pulse with `out_ready=1` -> 20 steps. `vector_0_in` runs 1..15, 0..4. `scala_1_in` alternates starting at 1. `vector_2_in` at step 12 is 13'h1000 and at step 13 is 13'h0001. `vector_3_in_2` at step 12 is 14. `done` pulses at T+21.
- **Backpressure**: toggle `out_ready` every cycle -> each step is held two cycles, the values are identical to the default run, and `done` pulses at T+41.
- **Abort and ignored start**:
  - `abort` at step 7 together with `out_ready=1` -> next cycle all outputs are 0 and there is no `done`.
  - `start` during RUN -> ignored, with no restart of `step_idx`.
- **`NUM_STEPS=1`, `SHIFT_MAX=0`**: `start` -> a single step with `vector_2_in=1`, then `done`, then IDLE. `start` asserted in the DONE cycle is ignored.
- **Loop**: with `VECTOR_STIM_LOOP_EN` defined -> after step 19, step 0 values reappear with `done=1` in the same cycle, and `out_valid` stays continuously high.
